// File: rtl/reset_seq.sv
// reset_seq: power-on reset sequencer for N dependent reset domains on one clock.
// All channels assert together on power-up, on reset_ni low or on req_i. They
// then release one at a time, channel 0 first: channel 0 after an initial hold,
// and each later channel D cycles after the previous one. done_o flags that
// every channel has been released.
// Optional watchdog, compiled in with `define RESET_SEQ_WDT_EN: in RUN, WDT
// cycles without a kick_i re-run the whole sequence and set the sticky wdt_o.
//
// Handshake: there is none. req_i and kick_i are level inputs sampled on every
// rising edge of clock. The outputs are registered and change only on that edge.
//
// Power-up values come from register initialisers, so the block also works on
// devices that have no reset line.
module reset_seq #(
  parameter int N    = 4,
  parameter int INIT = 16,
  parameter int D    = 8,
  parameter int WDT  = 1024,
  localparam int SW  = $clog2(N + 1)
) (
  input  logic          clock,
  input  logic          reset_ni,
  input  logic          req_i,
  input  logic          kick_i,
  output logic [N-1:0]  reset_o,
  output logic [SW-1:0] stage_o,
  output logic          done_o,
  output logic          wdt_o
);

  // Largest value the delay counter has to hold.
  localparam int SEQ_MAX = (INIT > D) ? INIT : D;
`ifdef RESET_SEQ_WDT_EN
  localparam int CNT_MAX = (SEQ_MAX > WDT) ? SEQ_MAX : WDT;
`else
  localparam int CNT_MAX = SEQ_MAX;
`endif
  localparam int CW = $clog2(CNT_MAX + 1);

  // Channel 0 is released on the INIT-th edge after the first quiet edge
  // (edge 0), so the HOLD count runs 0..INIT.
  localparam logic [CW-1:0] HOLD_LAST = CW'(INIT);
  localparam logic [CW-1:0] STEP_LAST = CW'(D - 1);
  localparam logic [SW-1:0] STAGE_N   = SW'(N);
  localparam logic [SW-1:0] STAGE_ONE = SW'(1);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    STEP = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Registered state. The initialisers give the power-up values.
  state_e          state_q = HOLD;
  logic [CW-1:0]   cnt_q   = '0;
  logic [SW-1:0]   stage_q = '0;
  logic [N-1:0]    reset_q = '1;
  logic            done_q  = 1'b0;

  state_e          state_d;
  logic [CW-1:0]   cnt_d;
  logic [SW-1:0]   stage_d;
  logic [N-1:0]    reset_d;
  logic            done_d;
  logic            wdt_trip;

`ifdef RESET_SEQ_WDT_EN
  logic            wdt_q = 1'b0;
`else
  logic            unused_kick;
  assign unused_kick = kick_i;
`endif

  // Next-state logic for the release sequence and the RUN watchdog.
  // Restarts are not handled here; they are applied in the register block.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stage_d  = stage_q;
    done_d   = done_q;
    wdt_trip = 1'b0;
    case (state_q)
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          stage_d = STAGE_ONE;
          if (N == 1) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            state_d = STEP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STEP: begin
        if (cnt_q == STEP_LAST) begin
          cnt_d   = '0;
          stage_d = stage_q + STAGE_ONE;
          if ((stage_q + STAGE_ONE) == STAGE_N) begin
            state_d = RUN;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
`ifdef RESET_SEQ_WDT_EN
        // The counter measures cycles since the last kick. A kick on the
        // trip edge itself still saves the sequence.
        if (kick_i) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(WDT - 1)) begin
          wdt_trip = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
        stage_d = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  // Reset mask is derived from the next stage: bit k asserted while k >= stage.
  always_comb begin
    reset_d = '0;
    for (int k = 0; k < N; k++) begin
      reset_d[k] = (k >= int'(stage_d));
    end
  end

  // State register. A restart (reset_ni low, req_i high or watchdog trip)
  // overrides every other transition on the same edge.
  always_ff @(posedge clock) begin
    if (!reset_ni || req_i || wdt_trip) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      stage_q <= '0;
      reset_q <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      reset_q <= reset_d;
      done_q  <= done_d;
    end
  end

`ifdef RESET_SEQ_WDT_EN
  // Sticky trip flag. Only reset_ni clears it; req_i leaves it alone.
  always_ff @(posedge clock) begin
    if (!reset_ni) begin
      wdt_q <= 1'b0;
    end else if (wdt_trip) begin
      wdt_q <= 1'b1;
    end
  end

  assign wdt_o = wdt_q;
`else
  assign wdt_o = 1'b0;
`endif

  assign reset_o = reset_q;
  assign stage_o = stage_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: directed checks of the reset sequencer with N=4, INIT=16, D=8,
// WDT=100. Edge numbers are counted from edge 0, the first edge after a
// restart or power-up at which reset_ni=1 and req_i=0.
module tb_reset_seq;

  localparam int N    = 4;
  localparam int INIT = 16;
  localparam int D    = 8;
  localparam int WDT  = 100;

  logic       clock = 1'b0;
  logic       reset_ni = 1'b1;
  logic       req_i = 1'b0;
  logic       kick_i = 1'b0;
  logic [3:0] reset_o;
  logic [2:0] stage_o;
  logic       done_o;
  logic       wdt_o;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  typedef struct {
    int         at;
    logic [3:0] exp_reset;
    logic [2:0] exp_stage;
    logic       exp_done;
  } vec_t;

  vec_t tbl[10];

  reset_seq #(.N(N), .INIT(INIT), .D(D), .WDT(WDT)) dut (
    .clock    (clock),
    .reset_ni (reset_ni),
    .req_i    (req_i),
    .kick_i   (kick_i),
    .reset_o  (reset_o),
    .stage_o  (stage_o),
    .done_o   (done_o),
    .wdt_o    (wdt_o)
  );

  // Clock.
  always #5 clock = ~clock;

  // One edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
    edge_n++;
  endtask

  // Advance until edge e has happened.
  task automatic run_to(input int e);
    while (edge_n <= e) tick();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got=%0h expected=%0h", name, edge_n - 1, got, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [3:0] r, input logic [2:0] s,
                           input logic dn, input logic w);
    check({name, ".reset_o"}, 32'(reset_o), 32'(r));
    check({name, ".stage_o"}, 32'(stage_o), 32'(s));
    check({name, ".done_o"},  32'(done_o),  32'(dn));
    check({name, ".wdt_o"},   32'(wdt_o),   32'(w));
  endtask

  // Full release sequence from edge 0, every row checked after its edge.
  task automatic apply_table(input string name, input logic exp_wdt);
    for (int i = 0; i < 10; i++) begin
      run_to(tbl[i].at);
      check_out($sformatf("%s[%0d]", name, tbl[i].at), tbl[i].exp_reset,
                tbl[i].exp_stage, tbl[i].exp_done, exp_wdt);
    end
  endtask

  initial begin
    tbl[0] = '{at: 0,  exp_reset: 4'hF, exp_stage: 3'd0, exp_done: 1'b0};
    tbl[1] = '{at: 15, exp_reset: 4'hF, exp_stage: 3'd0, exp_done: 1'b0};
    tbl[2] = '{at: 16, exp_reset: 4'hE, exp_stage: 3'd1, exp_done: 1'b0};
    tbl[3] = '{at: 23, exp_reset: 4'hE, exp_stage: 3'd1, exp_done: 1'b0};
    tbl[4] = '{at: 24, exp_reset: 4'hC, exp_stage: 3'd2, exp_done: 1'b0};
    tbl[5] = '{at: 31, exp_reset: 4'hC, exp_stage: 3'd2, exp_done: 1'b0};
    tbl[6] = '{at: 32, exp_reset: 4'h8, exp_stage: 3'd3, exp_done: 1'b0};
    tbl[7] = '{at: 39, exp_reset: 4'h8, exp_stage: 3'd3, exp_done: 1'b0};
    tbl[8] = '{at: 40, exp_reset: 4'h0, exp_stage: 3'd4, exp_done: 1'b1};
    tbl[9] = '{at: 60, exp_reset: 4'h0, exp_stage: 3'd4, exp_done: 1'b1};

    // Power-up values, before any edge.
    #1;
    check_out("powerup", 4'hF, 3'd0, 1'b0, 1'b0);

    // Power-up sequence with no reset applied.
    edge_n = 0;
    apply_table("seq_pwr", 1'b0);

    // One-cycle req_i pulse in RUN.
    req_i = 1'b1;
    tick();
    check_out("req_pulse", 4'hF, 3'd0, 1'b0, 1'b0);
    req_i = 1'b0;
    edge_n = 0;
    run_to(15);
    check_out("req_hold15", 4'hF, 3'd0, 1'b0, 1'b0);
    run_to(16);
    check_out("req_rel16", 4'hE, 3'd1, 1'b0, 1'b0);

    // reset_ni low for 3 cycles while stage is 2.
    run_to(28);
    check_out("mid_step", 4'hC, 3'd2, 1'b0, 1'b0);
    reset_ni = 1'b0;
    tick();
    check_out("rstn_first", 4'hF, 3'd0, 1'b0, 1'b0);
    tick();
    tick();
    check_out("rstn_third", 4'hF, 3'd0, 1'b0, 1'b0);
    reset_ni = 1'b1;
    edge_n = 0;
    apply_table("seq_rstn", 1'b0);

    // Restart on the same edge as the final stage step: restart wins.
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    edge_n = 0;
    run_to(39);
    check_out("pre_final", 4'h8, 3'd3, 1'b0, 1'b0);
    req_i = 1'b1;
    reset_ni = 1'b0;
    tick();
    check_out("final_clash", 4'hF, 3'd0, 1'b0, 1'b0);
    req_i = 1'b0;
    reset_ni = 1'b1;
    edge_n = 0;
    run_to(39);
    check_out("clash_39", 4'h8, 3'd3, 1'b0, 1'b0);
    run_to(40);
    check_out("clash_40", 4'h0, 3'd4, 1'b1, 1'b0);

`ifdef RESET_SEQ_WDT_EN
    // No kick: RUN was entered at edge 40, trip at edge 140.
    run_to(139);
    check_out("wdt_pre", 4'h0, 3'd4, 1'b1, 1'b0);
    run_to(140);
    check_out("wdt_trip", 4'hF, 3'd0, 1'b0, 1'b1);
    edge_n = 0;
    apply_table("seq_wdt", 1'b1);
    // req_i keeps the flag.
    req_i = 1'b1;
    tick();
    check_out("wdt_req_keep", 4'hF, 3'd0, 1'b0, 1'b1);
    req_i = 1'b0;
    // reset_ni clears it.
    reset_ni = 1'b0;
    tick();
    check_out("wdt_clear", 4'hF, 3'd0, 1'b0, 1'b0);
    reset_ni = 1'b1;
    edge_n = 0;
    run_to(40);
    check_out("kick_run", 4'h0, 3'd4, 1'b1, 1'b0);
    for (int c = 1; c <= 1000; c++) begin
      kick_i = (c % 50 == 0);
      tick();
      if (c % 100 == 0) check_out($sformatf("kick_%0d", c), 4'h0, 3'd4, 1'b1, 1'b0);
    end
    kick_i = 1'b0;
`else
    // Watchdog compiled out: RUN holds indefinitely without kicks.
    for (int c = 1; c <= 1000; c++) begin
      tick();
      if (c % 100 == 0) check_out($sformatf("nowdt_%0d", c), 4'h0, 3'd4, 1'b1, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
